apb_rd_engine: RTL and testbench



---
 rtl/apb_rd_engine.sv | 172 +++++++++++++++++
 tb/tb_apb_rd_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rd_engine.sv
// APB read engine: runs one AXI read command as len+1 sequential APB reads and
// returns each completed transfer as a registered read-data beat.
module apb_rd_engine #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [1:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [ID_WIDTH-1:0]   id_r, id_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic [7:0]            cnt_r, cnt_nxt_s;
  logic [2:0]            size_r, size_nxt_s;
  logic [1:0]            burst_r, burst_nxt_s;
  logic [DATA_WIDTH-1:0] data_r, data_nxt_s;
  logic [1:0]            resp_r, resp_nxt_s;
  logic                  last_r, last_nxt_s;
  logic                  valid_r, psel_r, penable_r, cmd_ready_r;
  logic                  cmd_illegal_s;
  logic [ADDR_WIDTH-1:0] step_s;

  assign cmd_illegal_s = cmd_burst[1] | (cmd_size > MAX_SIZE);
  // Only FIXED (burst 00) holds the address; wrap past all-ones is modular.
  assign step_s = (burst_r == 2'b00) ? {ADDR_WIDTH{1'b0}}
                                     : ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_r);

  // Next-state and next-value decode for the transfer sequencer.
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    addr_nxt_s  = addr_r;
    cnt_nxt_s   = cnt_r;
    size_nxt_s  = size_r;
    burst_nxt_s = burst_r;
    data_nxt_s  = data_r;
    resp_nxt_s  = resp_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          id_nxt_s    = cmd_id;
          addr_nxt_s  = cmd_addr;
          cnt_nxt_s   = cmd_len;
          size_nxt_s  = cmd_size;
          burst_nxt_s = cmd_burst;
          if (cmd_illegal_s) begin
            state_nxt_s = ERR;
            data_nxt_s  = {DATA_WIDTH{1'b0}};
            resp_nxt_s  = 2'b10;
            last_nxt_s  = (cmd_len == 8'd0);
          end else begin
            state_nxt_s = SETUP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: state_nxt_s = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_nxt_s = RESP;
          data_nxt_s  = prdata;
          resp_nxt_s  = pslverr ? 2'b10 : 2'b00;
          last_nxt_s  = (cnt_r == 8'd0);
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        if (r_ready && last_r) begin
          state_nxt_s = IDLE;
        end else if (r_ready) begin
          state_nxt_s = SETUP;
          cnt_nxt_s   = cnt_r - 8'd1;
          addr_nxt_s  = addr_r + step_s;
        end else begin
          state_nxt_s = RESP;
        end
      end
      ERR: begin
        // Error beats reuse the beat counter; r_last rises on the final one.
        if (r_ready && last_r) begin
          state_nxt_s = IDLE;
        end else if (r_ready) begin
          cnt_nxt_s  = cnt_r - 8'd1;
          last_nxt_s = (cnt_r == 8'd1);
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered outputs; APB/R controls are decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      id_r        <= {ID_WIDTH{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      cnt_r       <= 8'd0;
      size_r      <= 3'd0;
      burst_r     <= 2'b00;
      data_r      <= {DATA_WIDTH{1'b0}};
      resp_r      <= 2'b00;
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      id_r        <= id_nxt_s;
      addr_r      <= addr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      size_r      <= size_nxt_s;
      burst_r     <= burst_nxt_s;
      data_r      <= data_nxt_s;
      resp_r      <= resp_nxt_s;
      last_r      <= last_nxt_s;
      valid_r     <= (state_nxt_s == RESP) || (state_nxt_s == ERR);
      psel_r      <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
      penable_r   <= (state_nxt_s == ACCESS);
      cmd_ready_r <= (state_nxt_s == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = 1'b0;
  assign paddr     = addr_r;
  assign r_valid   = valid_r;
  assign r_id      = id_r;
  assign r_data    = data_r;
  assign r_resp    = resp_r;
  assign r_last    = last_r;

endmodule

// File: tb/tb_apb_rd_engine.sv
// Directed bench for apb_rd_engine: an APB slave model and an R-channel
// consumer check the DUT against queues filled by the stimulus sequence.
module tb_apb_rd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_id = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [7:0]  cmd_len = 8'd0;
  logic [1:0]  cmd_burst = 2'b00;
  logic [2:0]  cmd_size = 3'd0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        r_valid;
  logic        r_ready = 1'b1;
  logic [0:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          waits;
  } apb_t;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  apb_t  apb_q[$];
  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    apb_xfers = 0;
  int    acc_total = 0;
  int    rise_cyc = 0;
  int    last_acc_cyc = 0;
  int    stall_at = -1;
  int    stall_len = 0;
  int    c0 = 0;
  int    pushed = 0;
  int    x0 = 0;

  apb_rd_engine #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_apb(input logic [31:0] a, input logic [31:0] d, input logic e, input int w);
    apb_t t;
    t.addr = a; t.data = d; t.err = e; t.waits = w;
    apb_q.push_back(t);
  endtask

  task automatic push_exp(input logic [0:0] id, input logic [31:0] d, input logic [1:0] rsp,
                          input logic lst);
    beat_t b;
    b.id = id; b.data = d; b.resp = rsp; b.last = lst;
    exp_q.push_back(b);
    pushed++;
  endtask

  task automatic send_cmd(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_id = id; cmd_addr = a; cmd_len = len; cmd_burst = burst; cmd_size = size;
    cmd_valid = 1'b1;
    c0 = cyc;
    x0 = apb_xfers;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && apb_q.size() == 0 && cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_complete", {63'd0, (n < 300)}, 64'd1);
  endtask

  // APB slave: replays queued transfers with their wait states and errors.
  apb_t cur;
  logic busy = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      apb_q.delete();
      busy = 1'b0; wcnt = 0; pready = 1'b0; pslverr = 1'b0;
    end else if (psel && !penable) begin
      apb_xfers++;
      pready = 1'b0;
      if (apb_q.size() == 0) begin
        chk("apb_unexpected", {32'd0, paddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        busy = 1'b0;
      end else begin
        cur = apb_q.pop_front();
        busy = 1'b1; wcnt = 0;
        chk("apb_setup_addr", {32'd0, paddr}, {32'd0, cur.addr});
      end
    end else if (psel && penable && busy) begin
      chk("apb_access_addr", {32'd0, paddr}, {32'd0, cur.addr});
      if (wcnt < cur.waits) begin
        pready = 1'b0;
        wcnt++;
      end else begin
        pready = 1'b1; prdata = cur.data; pslverr = cur.err;
        busy = 1'b0;
      end
    end else begin
      pready = 1'b0; pslverr = 1'b0;
    end
  end

  // R consumer: optional stall on one beat, then pop and compare each beat.
  logic prev_v = 1'b0;
  int   scnt = 0;
  beat_t got;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      r_ready = 1'b1; scnt = 0; prev_v = 1'b0;
    end else begin
      if (r_valid && !prev_v) rise_cyc = cyc;
      prev_v = r_valid;
      if (r_valid && acc_total == stall_at && scnt < stall_len) begin
        r_ready = 1'b0;
        scnt++;
      end else if (r_valid) begin
        r_ready = 1'b1;
        if (exp_q.size() == 0) begin
          chk("r_unexpected", {32'd0, r_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          got = exp_q.pop_front();
          chk("r_id", {63'd0, r_id}, {63'd0, got.id});
          chk("r_data", {32'd0, r_data}, {32'd0, got.data});
          chk("r_resp", {62'd0, r_resp}, {62'd0, got.resp});
          chk("r_last", {63'd0, r_last}, {63'd0, got.last});
        end
        acc_total++;
        last_acc_cyc = cyc;
        scnt = 0;
      end else begin
        r_ready = 1'b1;
      end
    end
  end

  // Protocol monitor: penable implies psel, no APB while a beat waits, read-only.
  always @(negedge clk) begin
    if (!rst) begin
      chk("penable_wo_psel", {63'd0, (penable && !psel)}, 64'd0);
      chk("psel_during_resp", {63'd0, (psel && r_valid)}, 64'd0);
      chk("pwrite", {63'd0, pwrite}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
    chk("rst_paddr", {32'd0, paddr}, 64'd0);
    chk("rst_r_data", {32'd0, r_data}, 64'd0);
    chk("rst_r_resp_last_id", {60'd0, r_resp, r_last, r_id}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Single INCR beat, nominal latency.
    push_apb(32'h1000, 32'hDEAD_BEEF, 1'b0, 0);
    push_exp(1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1);
    send_cmd(1'b1, 32'h1000, 8'd0, 2'b01, 3'd2);
    wait_done();
    chk("single_rvalid_cycle", 64'(rise_cyc - c0), 64'd3);
    chk("single_apb_count", 64'(apb_xfers - x0), 64'd1);

    // INCR burst of 4, last beat accepted at cycle 12.
    for (int i = 0; i < 4; i++) begin
      push_apb(32'h2000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 0);
      push_exp(1'b0, 32'hA000_0000 + 32'(i), 2'b00, (i == 3));
    end
    send_cmd(1'b0, 32'h2000, 8'd3, 2'b01, 3'd2);
    wait_done();
    chk("incr_last_accept_cycle", 64'(last_acc_cyc - c0), 64'd12);
    chk("incr_apb_count", 64'(apb_xfers - x0), 64'd4);

    // FIXED burst with wait states and a 3-cycle stall on beat 1.
    stall_at = pushed + 1;
    stall_len = 3;
    for (int i = 0; i < 3; i++) begin
      push_apb(32'h5004, 32'h1111_1111 * 32'(i + 1), 1'b0, 2);
      push_exp(1'b1, 32'h1111_1111 * 32'(i + 1), 2'b00, (i == 2));
    end
    send_cmd(1'b1, 32'h5004, 8'd2, 2'b00, 3'd2);
    wait_done();
    stall_at = -1;
    chk("fixed_apb_count", 64'(apb_xfers - x0), 64'd3);

    // pslverr on the middle beat does not abort the burst.
    for (int i = 0; i < 3; i++) begin
      push_apb(32'h6000 + 32'(4 * i), 32'hB0B0_0000 + 32'(i), (i == 1), 0);
      push_exp(1'b0, 32'hB0B0_0000 + 32'(i), (i == 1) ? 2'b10 : 2'b00, (i == 2));
    end
    send_cmd(1'b0, 32'h6000, 8'd2, 2'b01, 3'd2);
    wait_done();
    chk("slverr_apb_count", 64'(apb_xfers - x0), 64'd3);

    // Illegal burst type: error beats only.
    push_exp(1'b1, 32'h0, 2'b10, 1'b0);
    push_exp(1'b1, 32'h0, 2'b10, 1'b1);
    send_cmd(1'b1, 32'h7000, 8'd1, 2'b10, 3'd2);
    wait_done();
    chk("bad_burst_apb_count", 64'(apb_xfers - x0), 64'd0);

    // Illegal size for a 32-bit bus.
    push_exp(1'b0, 32'h0, 2'b10, 1'b0);
    push_exp(1'b0, 32'h0, 2'b10, 1'b1);
    send_cmd(1'b0, 32'h7100, 8'd1, 2'b01, 3'd3);
    wait_done();
    chk("bad_size_apb_count", 64'(apb_xfers - x0), 64'd0);

    // Address wraps past all-ones.
    push_apb(32'hFFFF_FFFC, 32'h0000_00C1, 1'b0, 0);
    push_apb(32'h0000_0000, 32'h0000_00C2, 1'b0, 0);
    push_exp(1'b1, 32'h0000_00C1, 2'b00, 1'b0);
    push_exp(1'b1, 32'h0000_00C2, 2'b00, 1'b1);
    send_cmd(1'b1, 32'hFFFF_FFFC, 8'd1, 2'b01, 3'd2);
    wait_done();
    chk("wrap_apb_count", 64'(apb_xfers - x0), 64'd2);

    // Reset asserted in the middle of a waited ACCESS phase.
    push_apb(32'h3000, 32'h3333_3333, 1'b0, 10);
    push_exp(1'b0, 32'h3333_3333, 2'b00, 1'b1);
    send_cmd(1'b0, 32'h3000, 8'd0, 2'b01, 3'd2);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_access", {63'd0, (psel && penable)}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_psel", {63'd0, psel}, 64'd0);
    chk("midrst_penable", {63'd0, penable}, 64'd0);
    chk("midrst_r_valid", {63'd0, r_valid}, 64'd0);
    chk("midrst_paddr", {32'd0, paddr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Normal command after reset.
    push_apb(32'h4000, 32'hCAFE_F00D, 1'b0, 0);
    push_exp(1'b0, 32'hCAFE_F00D, 2'b00, 1'b1);
    send_cmd(1'b0, 32'h4000, 8'd0, 2'b01, 3'd2);
    wait_done();
    chk("post_rst_rvalid_cycle", 64'(rise_cyc - c0), 64'd3);
    chk("post_rst_apb_count", 64'(apb_xfers - x0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
